parity_monitor: RTL and testbench

PARITY_MONITOR -- requirements
Module: parity_monitor

---
 rtl/parity_monitor.sv | 133 +++++++++++++
 tb/tb_parity_monitor.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/parity_monitor.sv
// Parity monitor: checks each lane of a qualified word against its received parity,
// reports per-lane errors one cycle later and tracks erroneous words with a
// saturating counter, a sticky flag and a threshold alarm.
module parity_monitor #(
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned NUM_LANES   = 4,
   parameter int unsigned PARITY_TYPE = 0,
   parameter int unsigned CNT_WIDTH   = 16,
   parameter int unsigned ERR_THRESH  = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_WIDTH*NUM_LANES-1:0] data_in,
   input  logic [NUM_LANES-1:0]            parity_in,
   input  logic                            valid_in,
   input  logic                            clear_in,
   output logic                            valid_out,
   output logic [NUM_LANES-1:0]            lane_err_out,
   output logic                            err_out,
   output logic [CNT_WIDTH-1:0]            err_count_out,
   output logic                            sticky_err_out,
   output logic                            alarm_out,
   output logic [1:0]                      state_out
);

   // Comparison width wide enough for both the counter and the 32-bit threshold
   localparam int unsigned    CMP_W    = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;
   localparam logic           PAR_INV  = 1'(PARITY_TYPE);
   localparam logic           ALARM_EN = (ERR_THRESH != 0);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_OK    = 2'd0,
      ST_ERR   = 2'd1,
      ST_ALARM = 2'd2
   } state_t;

   state_t                 state_q;
   logic                   valid_q;
   logic [NUM_LANES-1:0]   lane_err_q;
   logic                   err_q;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [CNT_WIDTH-1:0]   cnt_d;
   logic                   sticky_q;
   logic                   alarm_q;

   logic [NUM_LANES-1:0]   lane_err_c;
   logic                   word_hit_c;
   logic                   thresh_hit_c;

   // Per-lane parity check of the incoming word
   always_comb begin
      lane_err_c = '0;
      for (int i = 0; i < int'(NUM_LANES); i++) begin
         lane_err_c[i] = (^data_in[i*DATA_WIDTH +: DATA_WIDTH]) ^ parity_in[i] ^ PAR_INV;
      end
   end

   // Counted error word, next count (clear wins, saturates at max) and threshold test
   always_comb begin
      word_hit_c = valid_in & (|lane_err_c) & ~clear_in;
      cnt_d      = cnt_q;
      if (clear_in) begin
         cnt_d = '0;
      end else if (word_hit_c && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
      thresh_hit_c = ALARM_EN && (CMP_W'(cnt_d) >= CMP_W'(ERR_THRESH));
   end

   // Result pipeline stage and error counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q    <= 1'b0;
         lane_err_q <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_in;
         lane_err_q <= valid_in ? lane_err_c : '0;
         err_q      <= valid_in & (|lane_err_c);
         cnt_q      <= cnt_d;
      end
   end

   // Monitor FSM with registered sticky/alarm decodes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_OK;
         sticky_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else if (clear_in) begin
         state_q  <= ST_OK;
         sticky_q <= 1'b0;
         alarm_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_OK, ST_ERR: begin
               if (word_hit_c) begin
                  if (thresh_hit_c) begin
                     state_q  <= ST_ALARM;
                     sticky_q <= 1'b1;
                     alarm_q  <= 1'b1;
                  end else begin
                     state_q  <= ST_ERR;
                     sticky_q <= 1'b1;
                     alarm_q  <= 1'b0;
                  end
               end
            end
            ST_ALARM: begin
               state_q  <= ST_ALARM;
               sticky_q <= 1'b1;
               alarm_q  <= 1'b1;
            end
            default: begin
               state_q  <= ST_OK;
               sticky_q <= 1'b0;
               alarm_q  <= 1'b0;
            end
         endcase
      end
   end

   assign valid_out      = valid_q;
   assign lane_err_out   = lane_err_q;
   assign err_out        = err_q;
   assign err_count_out  = cnt_q;
   assign sticky_err_out = sticky_q;
   assign alarm_out      = alarm_q;
   assign state_out      = state_q;

endmodule

// File: tb/tb_parity_monitor.sv
// Scoreboard bench: two monitors (even/16-bit counter and odd/2-bit counter) fed
// the same words; a reference model predicts each result and the counter/state.
module tb_parity_monitor;

   typedef struct packed {
      logic [3:0] le;
      logic       e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_in;
   logic [3:0]  parity_in;
   logic        valid_in;
   logic        clear_in;

   logic        v0, e0, s0, a0;
   logic [3:0]  le0;
   logic [15:0] c0;
   logic [1:0]  st0;
   logic        v1, e1, s1, a1;
   logic [3:0]  le1;
   logic [1:0]  c1;
   logic [1:0]  st1;

   int n_chk  = 0;
   int n_fail = 0;

   exp_t q0[$];
   exp_t q1[$];

   int unsigned mcnt[2];
   int unsigned mst[2];
   int unsigned cmax[2];
   int unsigned mptype[2];

   always #5 clk = ~clk;

   parity_monitor #(.DATA_WIDTH(8), .NUM_LANES(4), .PARITY_TYPE(0),
                    .CNT_WIDTH(16), .ERR_THRESH(4)) dut0 (
      .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
      .valid_in(valid_in), .clear_in(clear_in), .valid_out(v0),
      .lane_err_out(le0), .err_out(e0), .err_count_out(c0),
      .sticky_err_out(s0), .alarm_out(a0), .state_out(st0));

   parity_monitor #(.DATA_WIDTH(8), .NUM_LANES(4), .PARITY_TYPE(1),
                    .CNT_WIDTH(2), .ERR_THRESH(4)) dut1 (
      .clk(clk), .rst(rst), .data_in(data_in), .parity_in(parity_in),
      .valid_in(valid_in), .clear_in(clear_in), .valid_out(v1),
      .lane_err_out(le1), .err_out(e1), .err_count_out(c1),
      .sticky_err_out(s1), .alarm_out(a1), .state_out(st1));

   // Single comparison point
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Reference model of one monitor for the word on the inputs at the coming edge
   task automatic model_step(input int id);
      exp_t x;
      logic p;
      for (int i = 0; i < 4; i++) begin
         p = parity_in[i] ^ mptype[id][0];
         for (int b = 0; b < 8; b++) p = p ^ data_in[i*8+b];
         x.le[i] = p;
      end
      x.e = |x.le;
      if (clear_in) begin
         mcnt[id] = 0;
         mst[id]  = 0;
      end else if (valid_in && x.e) begin
         if (mcnt[id] != cmax[id]) mcnt[id] = mcnt[id] + 1;
         if (mst[id] != 2) mst[id] = (mcnt[id] >= 4) ? 2 : 1;
      end
      if (valid_in) begin
         if (id == 0) q0.push_back(x);
         else         q1.push_back(x);
      end
   endtask

   task automatic model_reset();
      for (int id = 0; id < 2; id++) begin
         mcnt[id] = 0;
         mst[id]  = 0;
      end
      q0.delete();
      q1.delete();
   endtask

   task automatic check_dut(input int id, input logic v, input logic [3:0] le, input logic e,
                            input logic [15:0] c, input logic s, input logic a,
                            input logic [1:0] st);
      exp_t x;
      string pfx;
      int qn;
      pfx = (id == 0) ? "d0_" : "d1_";
      qn  = (id == 0) ? q0.size() : q1.size();
      check({pfx, "valid"}, 32'(v), 32'(qn != 0));
      x = '0;
      if (qn != 0) x = (id == 0) ? q0.pop_front() : q1.pop_front();
      check({pfx, "lane_err"}, 32'(le), 32'(x.le));
      check({pfx, "err"}, 32'(e), 32'(x.e));
      check({pfx, "count"}, 32'(c), mcnt[id]);
      check({pfx, "state"}, 32'(st), mst[id]);
      check({pfx, "sticky"}, 32'(s), 32'(mst[id] != 0));
      check({pfx, "alarm"}, 32'(a), 32'(mst[id] == 2));
   endtask

   task automatic check_all();
      check_dut(0, v0, le0, e0, c0, s0, a0, st0);
      check_dut(1, v1, le1, e1, 16'(c1), s1, a1, st1);
   endtask

   // Drive one cycle of stimulus, advance an edge, then check both monitors
   task automatic drive(input logic [31:0] d, input logic [3:0] p, input logic v, input logic c);
      data_in   = d;
      parity_in = p;
      valid_in  = v;
      clear_in  = c;
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_v0"}, 32'(v0), 0);
      check({tag, "_le0"}, 32'(le0), 0);
      check({tag, "_e0"}, 32'(e0), 0);
      check({tag, "_c0"}, 32'(c0), 0);
      check({tag, "_s0"}, 32'(s0), 0);
      check({tag, "_a0"}, 32'(a0), 0);
      check({tag, "_st0"}, 32'(st0), 0);
      check({tag, "_v1"}, 32'(v1), 0);
      check({tag, "_c1"}, 32'(c1), 0);
      check({tag, "_st1"}, 32'(st1), 0);
   endtask

   initial begin
      cmax[0] = 65535; cmax[1] = 3;
      mptype[0] = 0;   mptype[1] = 1;
      model_reset();
      rst = 1'b1; data_in = '0; parity_in = '0; valid_in = 1'b0; clear_in = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      rst = 1'b0;

      // Clean word, then single-lane error word
      drive(32'h03030303, 4'b0000, 1'b1, 1'b0);
      drive(32'h01030303, 4'b0000, 1'b1, 1'b0);
      check("d0_le_1000", 32'(le0), 32'h8);
      check("d1_le_0111", 32'(le1), 32'h7);
      drive(32'h0, 4'b0000, 1'b0, 1'b0);

      // Three more error words with gaps: threshold on dut0, saturation on dut1
      for (int k = 0; k < 3; k++) begin
         drive(32'h01030303, 4'b0000, 1'b1, 1'b0);
         drive(32'hDEADBEEF, 4'b1111, 1'b0, 1'b0);
      end
      check("d0_count4", 32'(c0), 4);
      check("d0_alarm", 32'(a0), 1);
      drive(32'h000000FF, 4'b0001, 1'b1, 1'b0);
      drive(32'h01010101, 4'b1111, 1'b1, 1'b0);
      check("d1_sat3", 32'(c1), 3);

      // Clear with a concurrent error word
      drive(32'h01030303, 4'b0000, 1'b1, 1'b1);
      check("clr_c0", 32'(c0), 0);
      check("clr_st0", 32'(st0), 0);
      check("clr_le0", 32'(le0), 32'h8);
      drive(32'h0, 4'b0000, 1'b0, 1'b1);

      // Random traffic
      for (int k = 0; k < 200; k++) begin
         drive($urandom, 4'($urandom), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 24) == 0));
      end

      // Async reset mid-cycle with a word in flight and one sampled during reset
      drive(32'h01030303, 4'b0000, 1'b1, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      check_zero("arst");
      model_reset();
      data_in = 32'h01030303; parity_in = 4'b0000; valid_in = 1'b1;
      @(posedge clk);
      #1;
      check_zero("inrst");
      #3;
      rst = 1'b0;
      valid_in = 1'b0;
      #1;
      check_zero("rel");
      drive(32'h00000001, 4'b0000, 1'b1, 1'b0);
      check("post_le0", 32'(le0), 32'h1);
      drive(32'h0, 4'b0000, 1'b0, 1'b0);
      drive(32'h0, 4'b0000, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
